// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that loads one requester's word into a shared PIPO register,
// then holds it for HOLD_CYCLES cycles before accepting the next request.
module pipo_load_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned W           = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N-1:0]           i_req,
    input  logic [N*W-1:0]         i_din,
    output logic [N-1:0]           o_gnt,
    output logic                   o_load,
    output logic [W-1:0]           o_dout,
    output logic [$clog2(N)-1:0]   o_owner,
    output logic                   o_busy
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_gnt;
    logic            r_load;
    logic [W-1:0]    r_dout;
    logic [PW-1:0]   r_owner;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [PW-1:0]   w_ptr_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [N-1:0]    w_gnt_nxt;
    logic            w_load_nxt;
    logic [W-1:0]    w_dout_nxt;
    logic [PW-1:0]   w_owner_nxt;
    logic            w_busy_nxt;

    logic            w_found;
    logic [PW-1:0]   w_win;
    int unsigned     w_idx;

    // Winner: first set request bit scanning upward from the pointer, wrapping at N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = (32'(r_ptr) + i) % N;
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = '0;
        w_load_nxt  = 1'b0;
        w_dout_nxt  = r_dout;
        w_owner_nxt = r_owner;
        w_busy_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = CW'(HOLD_CYCLES - 1);
                    w_ptr_nxt   = (w_win == PW'(N - 1)) ? '0 : w_win + PW'(1);
                    w_gnt_nxt   = N'(1) << w_win;
                    w_load_nxt  = 1'b1;
                    w_dout_nxt  = i_din[32'(w_win)*W +: W];
                    w_owner_nxt = w_win;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt  = r_cnt - CW'(1);
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers; reset overrides any in-flight hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_load  <= 1'b0;
            r_dout  <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_load  <= w_load_nxt;
            r_dout  <= w_dout_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign o_gnt   = r_gnt;
    assign o_load  = r_load;
    assign o_dout  = r_dout;
    assign o_owner = r_owner;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed scenarios plus randomized traffic for pipo_load_arbiter, checked against
// a cycle-count reference model of the round-robin / hold rules.
module tb_pipo_load_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 4;
    localparam int unsigned HOLD = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  din;
    logic [N-1:0]    gnt;
    logic            load;
    logic [W-1:0]    dout;
    logic [1:0]      owner;
    logic            busy;

    int n_cmp;
    int n_err;
    int cyc;

    // Reference model state: remaining busy cycles replaces any explicit FSM.
    int          m_ptr;
    int          m_left;
    logic [N-1:0] m_gnt;
    logic        m_load;
    logic [W-1:0] m_dout;
    int          m_owner;

    pipo_load_arbiter #(.N(N), .W(W), .HOLD_CYCLES(HOLD)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_din   (din),
        .o_gnt   (gnt),
        .o_load  (load),
        .o_dout  (dout),
        .o_owner (owner),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        m_gnt  = '0;
        m_load = 1'b0;
        if (rst) begin
            m_ptr = 0; m_left = 0; m_dout = '0; m_owner = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (req != '0) begin
            for (int off = 0; off < N; off++) begin
                int k;
                k = (m_ptr + off) % N;
                if (req[k] && m_gnt == '0) begin
                    m_gnt   = N'(1) << k;
                    m_load  = 1'b1;
                    m_dout  = din[k*W +: W];
                    m_owner = k;
                    m_ptr   = (k + 1) % N;
                    m_left  = HOLD;
                end
            end
        end
    endtask

    task automatic tick(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
        rst = r; req = q; din = d;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        chk("gnt",   32'(gnt),   32'(m_gnt));
        chk("load",  32'(load),  32'(m_load));
        chk("dout",  32'(dout),  32'(m_dout));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("busy",  32'(busy),  32'(m_left > 0));
    endtask

    task automatic idle3();
        for (int i = 0; i < 3; i++) tick(1'b0, '0, din);
    endtask

    initial begin
        logic [N-1:0] q;
        int g_cyc[4];
        int g_own[4];
        int g_dat[4];
        int n_g;
        logic [N*W-1:0] words;

        n_cmp = 0; n_err = 0; cyc = 0;
        m_ptr = 0; m_left = 0; m_gnt = '0; m_load = 1'b0; m_dout = '0; m_owner = 0;
        rst = 1'b1; req = '0; din = '0;

        // 1: reset with all requests pending
        tick(1'b1, 4'b1111, 16'hFFFF);
        chk("t1_gnt", 32'(gnt), 0); chk("t1_busy", 32'(busy), 0); chk("t1_dout", 32'(dout), 0);
        tick(1'b1, 4'b1111, 16'hFFFF);
        chk("t1_load", 32'(load), 0); chk("t1_owner", 32'(owner), 0);
        tick(1'b0, '0, '0);

        // 2: single grant to index 2
        tick(1'b0, 4'b0100, 16'h0B00);
        chk("t2_gnt", 32'(gnt), 32'h4); chk("t2_load", 32'(load), 1);
        chk("t2_dout", 32'(dout), 32'hB); chk("t2_owner", 32'(owner), 2); chk("t2_busy1", 32'(busy), 1);
        tick(1'b0, '0, 16'h0B00);
        chk("t2_load_clr", 32'(load), 0); chk("t2_busy2", 32'(busy), 1);
        tick(1'b0, '0, 16'h0B00);
        chk("t2_idle", 32'(busy), 0); chk("t2_dout_hold", 32'(dout), 32'hB);

        // 3: round robin from ptr=0, requesters drop REQ once granted
        tick(1'b1, '0, '0);
        words = 16'h5B8A;
        q = 4'b1111;
        n_g = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, q, words);
            if (gnt != '0) begin
                if (n_g < 4) begin
                    g_cyc[n_g] = cyc; g_own[n_g] = int'(owner); g_dat[n_g] = int'(dout);
                end
                n_g++;
                q = q & ~gnt;
            end
        end
        chk("t3_count", 32'(n_g), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_owner", 32'(g_own[i]), 32'(i));
            chk("t3_dout", 32'(g_dat[i]), 32'(words[i*W +: W]));
            if (i > 0) chk("t3_spacing", 32'(g_cyc[i] - g_cyc[i-1]), HOLD + 1);
        end

        // 4: pointer wrap after a grant to index 2
        idle3();
        tick(1'b0, 4'b0100, 16'h1234);
        chk("t4_g2", 32'(gnt), 32'h4);
        tick(1'b0, '0, 16'h1234);
        tick(1'b0, '0, 16'h1234);
        tick(1'b0, 4'b1001, 16'h1234);
        chk("t4_g3", 32'(gnt), 32'h8); chk("t4_d3", 32'(dout), 32'h1);
        tick(1'b0, 4'b0001, 16'h1234);
        tick(1'b0, 4'b0001, 16'h1234);
        tick(1'b0, 4'b0001, 16'h1234);
        chk("t4_g0", 32'(gnt), 32'h1); chk("t4_d0", 32'(dout), 32'h4);

        // 5: requests and data changes during HOLD are ignored
        idle3();
        tick(1'b0, 4'b0001, 16'h1234);
        chk("t5_g0", 32'(gnt), 32'h1);
        tick(1'b0, 4'b0010, 16'hFFFF);
        chk("t5_nogntA", 32'(gnt), 0); chk("t5_doutA", 32'(dout), 32'h4);
        tick(1'b0, 4'b0010, 16'hEEEE);
        chk("t5_nogntB", 32'(gnt), 0); chk("t5_doutB", 32'(dout), 32'h4);
        tick(1'b0, 4'b0010, 16'hEEEE);
        chk("t5_g1", 32'(gnt), 32'h2); chk("t5_d1", 32'(dout), 32'hE);

        // 6: reset in the second HOLD cycle clears everything including ptr
        idle3();
        tick(1'b0, 4'b0100, 16'h0700);
        chk("t6_g2", 32'(gnt), 32'h4);
        tick(1'b0, '0, 16'h0700);
        tick(1'b1, '0, 16'h0700);
        chk("t6_busy", 32'(busy), 0); chk("t6_dout", 32'(dout), 0); chk("t6_owner", 32'(owner), 0);
        tick(1'b0, 4'b1010, 16'hC0D0);
        chk("t6_g1", 32'(gnt), 32'h2); chk("t6_own1", 32'(owner), 1); chk("t6_d1", 32'(dout), 32'hD);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 49) == 0), N'($urandom), (N*W)'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
